// File: rtl/dff_sync_debounce_pkg.sv
// Shared types, defaults and parameter legality check for the resynchronising debouncer.
// FSM encoding puts the settled level in bit 1, so LOW/HIGH decode directly to the output level.
package dff_sync_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW   = 2'b00,
        ST_CHK_H = 2'b01,
        ST_HIGH  = 2'b11,
        ST_CHK_L = 2'b10
    } state_e;

    localparam int unsigned N_SYNC_MIN  = 2;
    localparam int unsigned N_SYNC_MAX  = 4;
    localparam int unsigned DEB_CNT_MIN = 2;
    localparam int unsigned DEB_CNT_MAX = 255;

    localparam int unsigned N_SYNC_DEF  = 2;
    localparam int unsigned DEB_CNT_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned GC_W_DEF    = 8;

    // True when the parameter set is inside the supported range and the counter can reach DEB_CNT-1
    function automatic bit params_legal(input int unsigned n_sync,
                                        input int unsigned deb_cnt,
                                        input int unsigned cnt_w);
        bit ok;
        ok = (n_sync >= N_SYNC_MIN) && (n_sync <= N_SYNC_MAX) &&
             (deb_cnt >= DEB_CNT_MIN) && (deb_cnt <= DEB_CNT_MAX) &&
             (cnt_w >= 1) && (cnt_w < 32);
        if (ok) begin
            ok = ((64'd1 << cnt_w) > 64'(deb_cnt));
        end
        return ok;
    endfunction

endpackage

// File: rtl/dff_sync_debounce_if.sv
// Bundle between the debouncer and its consumer: raw bit and counter clear in, filtered status out.
interface dff_sync_debounce_if #(
    parameter int unsigned GC_W = 8
);
    logic            i_async;
    logic            i_clr_cnt;
    logic            o_level;
    logic            o_rise;
    logic            o_fall;
    logic            o_busy;
    logic [GC_W-1:0] o_glitch_cnt;

    modport master (
        output i_async,
        output i_clr_cnt,
        input  o_level,
        input  o_rise,
        input  o_fall,
        input  o_busy,
        input  o_glitch_cnt
    );

    modport slave (
        input  i_async,
        input  i_clr_cnt,
        output o_level,
        output o_rise,
        output o_fall,
        output o_busy,
        output o_glitch_cnt
    );
endinterface

// File: rtl/dff_sync_debounce_sync_chain.sv
// Plain N-stage resynchroniser; no logic between stages so the tool can place them back to back.
module dff_sync_chain #(
    parameter int unsigned N_SYNC = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);

    logic [N_SYNC-1:0] chain;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            chain <= '0;
        end else begin
            chain <= {chain[N_SYNC-2:0], i_d};
        end
    end

    assign o_q = chain[N_SYNC-1];

endmodule

// File: rtl/dff_sync_debounce.sv
// Resynchronises a possibly-asynchronous bit, debounces it and reports level, edge pulses
// and a saturating count of rejected candidate transitions.
module dff_sync_debounce
    import dff_sync_debounce_pkg::*;
#(
    parameter int unsigned N_SYNC  = N_SYNC_DEF,
    parameter int unsigned DEB_CNT = DEB_CNT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned GC_W    = GC_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    dff_sync_debounce_if.slave bus
);

    generate
        if (!params_legal(N_SYNC, DEB_CNT, CNT_W)) begin : g_param_err
            $error("dff_sync_debounce: illegal N_SYNC/DEB_CNT/CNT_W combination");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);
    localparam logic [GC_W-1:0]  GC_MAX   = '1;

    logic             s;
    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             rise_c;
    logic             fall_c;
    logic             reject_c;
    logic             busy_c;
    logic             level_c;

    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;
    logic [GC_W-1:0]  glitch_q;

    dff_sync_chain #(
        .N_SYNC (N_SYNC)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (bus.i_async),
        .o_q    (s)
    );

    // State and debounce counter registers
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= ST_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a candidate level must be seen DEB_CNT samples in a row to be accepted
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_LOW: begin
                if (s) begin
                    state_nxt = ST_CHK_H;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_CHK_H: begin
                if (!s) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    state_nxt = ST_CHK_L;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_CHK_L: begin
                if (s) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the transition about to happen
    always_comb begin
        rise_c   = (state == ST_CHK_H) && (state_nxt == ST_HIGH);
        fall_c   = (state == ST_CHK_L) && (state_nxt == ST_LOW);
        reject_c = ((state == ST_CHK_H) && (state_nxt == ST_LOW)) ||
                   ((state == ST_CHK_L) && (state_nxt == ST_HIGH));
        busy_c   = (state_nxt == ST_CHK_H) || (state_nxt == ST_CHK_L);
        level_c  = level_q;
        if ((state_nxt == ST_LOW) || (state_nxt == ST_HIGH)) begin
            level_c = state_nxt[1];
        end
    end

    // Registered outputs; the counter clear takes priority over a same-cycle rejection
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            level_q <= level_c;
            rise_q  <= rise_c;
            fall_q  <= fall_c;
            busy_q  <= busy_c;
            if (bus.i_clr_cnt) begin
                glitch_q <= '0;
            end else if (reject_c && (glitch_q != GC_MAX)) begin
                glitch_q <= glitch_q + GC_W'(1);
            end
        end
    end

    assign bus.o_level      = level_q;
    assign bus.o_rise       = rise_q;
    assign bus.o_fall       = fall_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_glitch_cnt = glitch_q;

endmodule

// File: tb/tb_dff_sync_debounce.sv
// Directed plus random checks of dff_sync_debounce against a run-length reference model.
module tb_dff_sync_debounce;

    localparam int unsigned N_SYNC  = 2;
    localparam int unsigned DEB_CNT = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned GC_W    = 8;
    localparam int          GC_MAX  = (1 << GC_W) - 1;

    logic i_clk = 1'b0;
    logic i_rstn;

    always #5 i_clk = ~i_clk;

    dff_sync_debounce_if #(.GC_W(GC_W)) bus ();

    dff_sync_debounce #(
        .N_SYNC  (N_SYNC),
        .DEB_CNT (DEB_CNT),
        .CNT_W   (CNT_W),
        .GC_W    (GC_W)
    ) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: a delay line of N_SYNC samples, then a count of consecutive samples
    // that disagree with the accepted level.
    bit dly[$];
    int m_level  = 0;
    int m_run    = 0;
    int m_glitch = 0;
    int m_rise   = 0;
    int m_fall   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit a, input bit clr, input bit rstn);
        bit s;
        if (!rstn) begin
            dly = {};
            for (int i = 0; i < int'(N_SYNC); i++) dly.push_back(1'b0);
            m_level = 0; m_run = 0; m_glitch = 0; m_rise = 0; m_fall = 0;
        end else begin
            s = dly.pop_front();
            dly.push_back(a);
            m_rise = 0;
            m_fall = 0;
            if (int'(s) != m_level) begin
                m_run++;
                if (m_run == int'(DEB_CNT)) begin
                    m_level = int'(s);
                    m_run   = 0;
                    m_rise  = int'(s);
                    m_fall  = int'(!s);
                end
            end else begin
                if (m_run > 0 && m_glitch < GC_MAX) m_glitch++;
                m_run = 0;
            end
            if (clr) m_glitch = 0;
        end
    endtask

    task automatic step(input bit a, input bit clr, input bit rstn);
        bus.i_async   = a;
        bus.i_clr_cnt = clr;
        i_rstn        = rstn;
        @(posedge i_clk);
        model_edge(a, clr, rstn);
        #1;
        chk("level",  int'(bus.o_level), m_level);
        chk("rise",   int'(bus.o_rise),  m_rise);
        chk("fall",   int'(bus.o_fall),  m_fall);
        chk("busy",   int'(bus.o_busy),  int'(m_run > 0));
        chk("glitch", int'(bus.o_glitch_cnt), m_glitch);
        chk("pulse_excl", int'(bus.o_rise && bus.o_fall), 0);
    endtask

    int  rise_edge, fall_edge, fall_count, busy_seen, rise_seen;
    bit  a_rand;
    int  len;

    initial begin
        bus.i_async   = 1'b0;
        bus.i_clr_cnt = 1'b0;
        i_rstn        = 1'b0;
        for (int i = 0; i < int'(N_SYNC); i++) dly.push_back(1'b0);

        // Reset with input high, then release and time the rise
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk("rst_level", int'(bus.o_level), 0);
        chk("rst_glitch", int'(bus.o_glitch_cnt), 0);
        rise_edge = 0;
        for (int e = 1; e <= 12; e++) begin
            step(1'b1, 1'b0, 1'b1);
            if (bus.o_rise && rise_edge == 0) rise_edge = e;
        end
        chk("rise_latency", rise_edge, 6);
        chk("level_after_rise", int'(bus.o_level), 1);

        // Clean fall
        fall_edge = 0; fall_count = 0;
        for (int e = 1; e <= 10; e++) begin
            step(1'b0, 1'b0, 1'b1);
            if (bus.o_fall) begin
                fall_count++;
                if (fall_edge == 0) fall_edge = e;
            end
        end
        chk("fall_latency", fall_edge, 6);
        chk("fall_count", fall_count, 1);
        chk("level_after_fall", int'(bus.o_level), 0);
        chk("glitch_after_fall", int'(bus.o_glitch_cnt), 0);

        // Two-cycle glitch is rejected
        busy_seen = 0;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int e = 0; e < 6; e++) begin
            if (bus.o_busy) busy_seen = 1;
            step(1'b0, 1'b0, 1'b1);
            if (bus.o_busy) busy_seen = 1;
        end
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_level", int'(bus.o_level), 0);
        chk("glitch_count1", int'(bus.o_glitch_cnt), 1);

        // Saturation, then clear colliding with a rejection
        for (int g = 0; g < 300; g++) begin
            step(1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1);
        end
        chk("glitch_sat", int'(bus.o_glitch_cnt), GC_MAX);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("busy_before_clr", int'(bus.o_busy), 1);
        step(1'b0, 1'b1, 1'b1);
        chk("clr_wins", int'(bus.o_glitch_cnt), 0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("clr_hold", int'(bus.o_glitch_cnt), 0);

        // Reset part-way through qualifying a rise
        rise_seen = 0;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("midq_busy", int'(bus.o_busy), 1);
        step(1'b1, 1'b0, 1'b0);
        if (bus.o_rise) rise_seen = 1;
        chk("midq_no_rise", rise_seen, 0);
        chk("midq_level", int'(bus.o_level), 0);
        chk("midq_busy_cleared", int'(bus.o_busy), 0);
        chk("midq_glitch", int'(bus.o_glitch_cnt), 0);
        repeat (4) step(1'b0, 1'b0, 1'b1);

        // Corrupted upstream pulses: one between edges, one caught for a single sample
        #2 bus.i_async = 1'b1;
        #3 bus.i_async = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("between_edges_glitch", int'(bus.o_glitch_cnt), 0);
        step(1'b1, 1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 1'b1);
        chk("upstream_level", int'(bus.o_level), 0);
        chk("upstream_glitch", int'(bus.o_glitch_cnt), 1);

        // Random runs of varying length, occasional clear and reset
        a_rand = 1'b0;
        for (int r = 0; r < 500; r++) begin
            a_rand = ~a_rand;
            len = int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) begin
                step(a_rand, ($urandom_range(0, 31) == 0), ($urandom_range(0, 299) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
